// File: rtl/raizing_sdram_pkg.sv
// raizing_sdram_pkg: shared FSM state type and slot count for the bank arbiter.
package raizing_sdram_pkg;
  localparam int NSLOTS = 4;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DST, WAIT_W1} state_t;
endpackage

// File: rtl/raizing_rr_pick.sv
// raizing_rr_pick: 4-way round-robin picker, search starts at last_grant+1.
module raizing_rr_pick
  import raizing_sdram_pkg::*;
(
  input  logic [NSLOTS-1:0] i_pending,
  input  logic [1:0]        i_last,
  output logic [1:0]        o_grant,
  output logic              o_any
);
  always_comb begin
    o_grant = i_last;
    o_any = |i_pending;
    // Descending scan so the nearest slot after i_last overrides farther ones.
    for (int k = NSLOTS; k >= 1; k--)
      if (i_pending[2'(i_last + 2'(k))]) o_grant = 2'(i_last + 2'(k));
  end
endmodule

// File: rtl/raizing_bank_arbiter.sv
// raizing_bank_arbiter: four read slots with one-entry caches sharing one SDRAM bank,
// arbitrated round-robin with a single outstanding two-word read.
module raizing_bank_arbiter
  import raizing_sdram_pkg::*;
#(
  parameter int                SDRAMW       = 22,
  parameter int                SLOT_AW      = 21,
  parameter logic [SDRAMW-1:0] SLOT0_OFFSET = '0,
  parameter logic [SDRAMW-1:0] SLOT1_OFFSET = '0,
  parameter logic [SDRAMW-1:0] SLOT2_OFFSET = '0,
  parameter logic [SDRAMW-1:0] SLOT3_OFFSET = '0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               SLOT0_CS,
  input  logic               SLOT1_CS,
  input  logic               SLOT2_CS,
  input  logic               SLOT3_CS,
  input  logic [SLOT_AW-1:0] SLOT0_ADDR,
  input  logic [SLOT_AW-1:0] SLOT1_ADDR,
  input  logic [SLOT_AW-1:0] SLOT2_ADDR,
  input  logic [SLOT_AW-1:0] SLOT3_ADDR,
  output logic               SLOT0_OK,
  output logic               SLOT1_OK,
  output logic               SLOT2_OK,
  output logic               SLOT3_OK,
  output logic [31:0]        SLOT0_DOUT,
  output logic [31:0]        SLOT1_DOUT,
  output logic [31:0]        SLOT2_DOUT,
  output logic [31:0]        SLOT3_DOUT,
  output logic [SDRAMW-1:0]  SDRAM_ADDR,
  output logic               SDRAM_REQ,
  input  logic               SDRAM_ACK,
  input  logic               DATA_DST,
  input  logic               DATA_RDY,
  input  logic [15:0]        DATA_READ
);
  state_t              r_state, w_next;
  logic [NSLOTS-1:0]   r_valid;
  logic [SLOT_AW-1:0]  r_tag [NSLOTS];
  logic [31:0]         r_data [NSLOTS];
  logic [1:0]          r_slot, r_last;
  logic [SLOT_AW-1:0]  r_addr;
  logic [SDRAMW-1:0]   r_sdram_addr;
  logic                r_req;
  logic [NSLOTS-1:0]   w_cs, w_ok, w_pending;
  logic [SLOT_AW-1:0]  w_addr [NSLOTS];
  logic [SDRAMW-1:0]   w_off [NSLOTS];
  logic [1:0]          w_grant;
  logic                w_any;
  assign w_cs = {SLOT3_CS, SLOT2_CS, SLOT1_CS, SLOT0_CS};
  assign w_addr[0] = SLOT0_ADDR;
  assign w_addr[1] = SLOT1_ADDR;
  assign w_addr[2] = SLOT2_ADDR;
  assign w_addr[3] = SLOT3_ADDR;
  assign w_off[0] = SLOT0_OFFSET;
  assign w_off[1] = SLOT1_OFFSET;
  assign w_off[2] = SLOT2_OFFSET;
  assign w_off[3] = SLOT3_OFFSET;
  for (genvar i = 0; i < NSLOTS; i++) begin : g_hit
    assign w_ok[i] = w_cs[i] & r_valid[i] & (r_tag[i] == w_addr[i]);
  end
  assign w_pending = w_cs & ~w_ok;
  assign {SLOT3_OK, SLOT2_OK, SLOT1_OK, SLOT0_OK} = w_ok;
  assign SLOT0_DOUT = r_data[0];
  assign SLOT1_DOUT = r_data[1];
  assign SLOT2_DOUT = r_data[2];
  assign SLOT3_DOUT = r_data[3];
  assign SDRAM_ADDR = r_sdram_addr;
  assign SDRAM_REQ = r_req;
  raizing_rr_pick u_pick (
    .i_pending(w_pending),
    .i_last   (r_last),
    .o_grant  (w_grant),
    .o_any    (w_any)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_any ? WAIT_ACK : IDLE;
      WAIT_ACK: w_next = SDRAM_ACK ? WAIT_DST : WAIT_ACK;
      WAIT_DST: w_next = DATA_DST ? WAIT_W1 : WAIT_DST;
      WAIT_W1:  w_next = DATA_RDY ? IDLE : WAIT_W1;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid <= '0;
      for (int n = 0; n < NSLOTS; n++) begin
        r_tag[n] <= '0;
        r_data[n] <= '0;
      end
      r_slot <= '0;
      r_last <= 2'd3;
      r_addr <= '0;
      r_sdram_addr <= '0;
      r_req <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_slot <= w_grant;
        r_addr <= w_addr[w_grant];
        r_sdram_addr <= SDRAMW'({w_addr[w_grant], 1'b0}) + w_off[w_grant];
        r_req <= 1'b1;
      end
      if (r_state == WAIT_ACK && SDRAM_ACK) r_req <= 1'b0;
      if (r_state == WAIT_DST && DATA_DST) r_data[r_slot][15:0] <= DATA_READ;
      // The tag comes from the latched address, so a slot that moved on keeps missing.
      if (r_state == WAIT_W1 && DATA_RDY) begin
        r_data[r_slot][31:16] <= DATA_READ;
        r_tag[r_slot] <= r_addr;
        r_valid[r_slot] <= 1'b1;
        r_last <= r_slot;
      end
    end
  end
endmodule
